// File: rtl/dcache_flush_sched.sv
// Coalescing D-cache flush scheduler: snapshots pending requesters, holds one flush, acks them all.
// Optional watchdog compiled in with `define DCACHE_FLUSH_SCHED_TIMEOUT_EN.
module dcache_flush_sched #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned TO_W    = 16
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [NUM_REQ-1:0] req_i,
   output logic [NUM_REQ-1:0] ack_o,
   output logic               flush_dcache_o,
   input  logic               flush_dcache_ack_i,
   output logic               busy_o,
   output logic [NUM_REQ-1:0] served_mask_o,
   input  logic [TO_W-1:0]    to_limit_i,
   output logic               timeout_o
);

   typedef enum logic [1:0] {StIdle, StFlush, StAck} state_e;

   state_e             state_q, state_d;
   logic [NUM_REQ-1:0] mask_q, mask_d;
   logic               flush_q, flush_d;
   logic               timeout_q, timeout_d;
   logic               wd_fire;

`ifdef DCACHE_FLUSH_SCHED_TIMEOUT_EN
   logic [TO_W-1:0] cnt_q, cnt_d;

   // A cache ack in the same cycle wins over the watchdog.
   assign wd_fire = (to_limit_i != '0) && (cnt_q == to_limit_i - TO_W'(1)) && !flush_dcache_ack_i;

   always_comb begin
      cnt_d = cnt_q;
      if (state_q == StIdle && |req_i) begin
         cnt_d = '0;
      end else if (state_q == StFlush && cnt_q != '1) begin
         cnt_d = cnt_q + TO_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   logic unused_to_limit;
   assign unused_to_limit = ^to_limit_i;
   assign wd_fire         = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      mask_d    = mask_q;
      flush_d   = flush_q;
      timeout_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (|req_i) begin
               state_d = StFlush;
               mask_d  = req_i;
               flush_d = 1'b1;
            end
         end
         StFlush: begin
            if (flush_dcache_ack_i || wd_fire) begin
               state_d   = StAck;
               flush_d   = 1'b0;
               timeout_d = wd_fire;
            end
         end
         StAck: begin
            state_d = StIdle;
            mask_d  = '0;
         end
         default: begin
            state_d = StIdle;
            mask_d  = '0;
            flush_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= StIdle;
         mask_q    <= '0;
         flush_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         mask_q    <= mask_d;
         flush_q   <= flush_d;
         timeout_q <= timeout_d;
      end
   end

   assign ack_o          = (state_q == StAck) ? mask_q : '0;
   assign flush_dcache_o = flush_q;
   assign busy_o         = (state_q != StIdle);
   assign served_mask_o  = mask_q;
   assign timeout_o      = timeout_q;

endmodule

// File: tb/tb_dcache_flush_sched.sv
// Self-checking bench for dcache_flush_sched: directed vector table, hand sequences, random vs model.
module tb_dcache_flush_sched;
   localparam int unsigned N    = 4;
   localparam int unsigned TO_W = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req;
   logic [N-1:0]    ack;
   logic            flush;
   logic            cack;
   logic            busy;
   logic [N-1:0]    served;
   logic [TO_W-1:0] limit;
   logic            tout;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dcache_flush_sched #(
      .NUM_REQ(N),
      .TO_W   (TO_W)
   ) dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .req_i             (req),
      .ack_o             (ack),
      .flush_dcache_o    (flush),
      .flush_dcache_ack_i(cack),
      .busy_o            (busy),
      .served_mask_o     (served),
      .to_limit_i        (limit),
      .timeout_o         (tout)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all(input string tag, input logic e_flush, input logic [N-1:0] e_ack,
                            input logic e_busy, input logic [N-1:0] e_served, input logic e_to);
      check({tag, ".flush"}, 32'(flush), 32'(e_flush));
      check({tag, ".ack"}, 32'(ack), 32'(e_ack));
      check({tag, ".busy"}, 32'(busy), 32'(e_busy));
      check({tag, ".served"}, 32'(served), 32'(e_served));
      check({tag, ".timeout"}, 32'(tout), 32'(e_to));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Vector: inputs sampled at an edge, outputs expected right after it.
   typedef struct {
      logic         rst;
      logic [N-1:0] req;
      logic         cack;
      logic         e_flush;
      logic [N-1:0] e_ack;
      logic         e_busy;
      logic [N-1:0] e_served;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic [N-1:0] q, input logic c, input logic f,
                      input logic [N-1:0] a, input logic b, input logic [N-1:0] s);
      vec_t v;
      v.rst = r; v.req = q; v.cack = c; v.e_flush = f; v.e_ack = a; v.e_busy = b; v.e_served = s;
      vecs.push_back(v);
   endtask

   // Reference model: a flush is outstanding, then one completion cycle acks its snapshot.
   logic         m_flushing, m_acking, m_to;
   logic [N-1:0] m_snap;
   int           m_wait;
   bit           wd_en;

   task automatic model_reset();
      m_flushing = 0; m_acking = 0; m_to = 0; m_snap = '0; m_wait = 0;
   endtask

   task automatic model_step(input logic [N-1:0] r, input logic c, input logic [TO_W-1:0] lim);
      bit expired;
      if (m_acking) begin
         m_acking = 0; m_snap = '0; m_to = 0;
      end else if (m_flushing) begin
         expired = wd_en && lim != 0 && m_wait == int'(lim) - 1;
         if (c || expired) begin
            m_flushing = 0; m_acking = 1; m_to = !c && expired;
         end else begin
            m_wait++;
         end
      end else if (r != '0) begin
         m_flushing = 1; m_snap = r; m_wait = 0;
      end
   endtask

   initial begin
      logic [N-1:0] prev_ack;
      logic [N-1:0] raise;
`ifdef DCACHE_FLUSH_SCHED_TIMEOUT_EN
      wd_en = 1;
`else
      wd_en = 0;
`endif
      rst = 1; req = '0; cack = 0; limit = '0;

      // Reset, single request (cache ack 5 cycles after flush rises), spurious ack,
      // coalescing with late arrival and back-to-back, minimum latency.
      add(1, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000);
      add(0, 4'b0001, 0, 1, 4'b0000, 1, 4'b0001);
      for (int i = 0; i < 4; i++) add(0, 4'b0001, 0, 1, 4'b0000, 1, 4'b0001);
      add(0, 4'b0001, 1, 0, 4'b0001, 1, 4'b0001);
      add(0, 4'b0001, 0, 0, 4'b0000, 0, 4'b0000);
      add(0, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000);
      add(0, 4'b0000, 1, 0, 4'b0000, 0, 4'b0000);
      add(0, 4'b0101, 0, 1, 4'b0000, 1, 4'b0101);
      add(0, 4'b0101, 0, 1, 4'b0000, 1, 4'b0101);
      add(0, 4'b1101, 0, 1, 4'b0000, 1, 4'b0101);
      add(0, 4'b1101, 1, 0, 4'b0101, 1, 4'b0101);
      add(0, 4'b1101, 0, 0, 4'b0000, 0, 4'b0000);
      add(0, 4'b1000, 0, 1, 4'b0000, 1, 4'b1000);
      add(0, 4'b1000, 1, 0, 4'b1000, 1, 4'b1000);
      add(0, 4'b1000, 0, 0, 4'b0000, 0, 4'b0000);
      add(0, 4'b0010, 0, 1, 4'b0000, 1, 4'b0010);
      add(0, 4'b0010, 1, 0, 4'b0010, 1, 4'b0010);
      add(0, 4'b0010, 0, 0, 4'b0000, 0, 4'b0000);
      add(0, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000);

      #2;
      for (int i = 0; i < vecs.size(); i++) begin
         rst = vecs[i].rst; req = vecs[i].req; cack = vecs[i].cack;
         tick();
         check_all($sformatf("vec%0d", i), vecs[i].e_flush, vecs[i].e_ack, vecs[i].e_busy,
                   vecs[i].e_served, 1'b0);
      end

      // Reset mid-flush, then a late cache ack after release.
      rst = 0; req = 4'b0100; cack = 0;
      tick();
      check_all("rst_pre", 1, 4'b0000, 1, 4'b0100, 0);
      tick();
      rst = 1; req = '0;
      tick();
      check_all("rst_mid", 0, 4'b0000, 0, 4'b0000, 0);
      rst = 0; cack = 1;
      tick();
      check_all("rst_lateack", 0, 4'b0000, 0, 4'b0000, 0);
      cack = 0;
      tick();
      check_all("rst_after", 0, 4'b0000, 0, 4'b0000, 0);

      // Watchdog limit 8 without a cache ack.
      limit = 16'd8; req = 4'b0001;
      for (int i = 0; i < 8; i++) begin
         tick();
         check_all($sformatf("wd8_c%0d", i), 1, 4'b0000, 1, 4'b0001, 0);
      end
      if (wd_en) begin
         tick();
         check_all("wd8_fire", 0, 4'b0001, 1, 4'b0001, 1);
         tick();
         check_all("wd8_idle", 0, 4'b0000, 0, 4'b0000, 0);
         req = '0;
      end else begin
         for (int i = 0; i < 30; i++) begin
            tick();
            check_all("nowd_wait", 1, 4'b0000, 1, 4'b0001, 0);
         end
         cack = 1;
         tick();
         check_all("nowd_ack", 0, 4'b0001, 1, 4'b0001, 0);
         cack = 0;
         tick();
         req = '0;
      end
      tick();

      // Limit 0 disables the watchdog.
      limit = '0; req = 4'b0010;
      for (int i = 0; i < 40; i++) begin
         tick();
         check_all("wd0_wait", 1, 4'b0000, 1, 4'b0010, 0);
      end
      cack = 1;
      tick();
      check_all("wd0_ack", 0, 4'b0010, 1, 4'b0010, 0);
      cack = 0;
      tick();
      req = '0;
      tick();

      // Random protocol-following requesters against the model.
      rst = 1;
      tick();
      rst = 0;
      model_reset();
      limit = 16'd5;
      prev_ack = '0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         if (cyc == 750) limit = 16'd3;
         raise = N'($urandom) & N'($urandom) & N'($urandom);
         req   = (req & ~prev_ack) | (raise & ~req);
         cack  = ($urandom_range(0, 5) == 0);
         model_step(req, cack, limit);
         tick();
         check_all("rand", m_flushing, m_acking ? m_snap : '0, m_flushing | m_acking, m_snap,
                   m_acking & m_to);
         prev_ack = m_acking ? m_snap : '0;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/dcache_flush_sched.md
# dcache_flush_sched

Coalescing scheduler that shares the single D-cache flush handshake between several requesters: fence, fence.i, fence.t, debug and CSR-triggered flushes. It snapshots every pending request when a flush starts, holds the flush request until the cache acknowledges, then acknowledges all snapshotted requesters together. It sits between the flush controller and the D-cache. It replaces ad-hoc per-source flush-active flags with one FSM, and reports busy so the core can halt while a flush is in flight.

## Interface
Parameters:
- NUM_REQ, default 4: number of flush requesters (≥1).
- TO_W, default 16: width of the watchdog timeout counter and limit.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- req_i  in  NUM_REQ  per-requester flush request, level, held until ack_o.
- ack_o  out  NUM_REQ  per-requester completion, one-cycle pulse.
- flush_dcache_o  out  1  flush request to D-cache, registered.
- flush_dcache_ack_i  in  1  D-cache flush-complete pulse.
- busy_o  out  1  high whenever state ≠ IDLE; feeds the commit-stage halt.
- served_mask_o  out  NUM_REQ  snapshot of the requesters covered by the current flush.
- to_limit_i  in  TO_W  watchdog limit in cycles; 0 disables the watchdog.
- timeout_o  out  1  one-cycle pulse when the watchdog fires.

## Operation
- FSM states: IDLE, FLUSH, ACK. Reset state is IDLE.
- IDLE → FLUSH when |req_i.
  - On this transition: mask_q ← req_i; flush_dcache_o ← 1; watchdog counter ← 0.
- FLUSH:
  - flush_dcache_o is held at 1.
  - On flush_dcache_ack_i, go to ACK and set flush_dcache_o ← 0.
- ACK:
  - ack_o = mask_q for exactly this cycle.
  - Next state is IDLE and mask_q ← 0.
- Coalescing rules:
  - A request asserted while in FLUSH or ACK is not in mask_q. It is served by the next flush.
  - A whole-cache flush satisfies every requester in the snapshot.
- Requester protocol:
  - A requester deasserts req_i on the clock edge after it sees its ack_o.
  - IDLE therefore never sees a stale request.
  - If req_i drops before ack_o, that is a protocol violation. mask_q is unaffected and ack_o still pulses.
- flush_dcache_ack_i is ignored in IDLE and ACK.
- served_mask_o = mask_q.
- Reset values: ack_o=0, flush_dcache_o=0, busy_o=0, served_mask_o=0, timeout_o=0, state IDLE, counter 0.
- Reset mid-flush: all of the above apply on the next edge. The pending flush is abandoned with no ack_o. A late cache ack after reset is ignored, since the FSM is in IDLE.

## Timing
- Request sampled high in IDLE at edge n:
  - flush_dcache_o and busy_o are high from cycle n+1.
- Cache ack sampled in FLUSH at edge k:
  - flush_dcache_o is low from k+1.
  - ack_o pulses during cycle k+1 (state ACK).
  - State is IDLE from k+2.
- Minimum round trip: the ack arrives in the first FLUSH cycle. Total is 3 cycles from the request edge to IDLE.
- Back-to-back: a request waiting during ACK starts the next flush at k+2, with flush_dcache_o high at k+3.
- Same-cycle events: in FLUSH, a cache ack wins over a watchdog expiry in the same cycle. timeout_o stays 0.

## Configuration
- Macro `DCACHE_FLUSH_SCHED_TIMEOUT_EN` defined (watchdog compiled in):
  - A TO_W-bit counter increments every FLUSH cycle and saturates at all-ones.
  - When to_limit_i ≠ 0, the counter equals to_limit_i−1, and flush_dcache_ack_i is low, the watchdog fires:
    - timeout_o pulses next cycle, coincident with ACK.
    - The FSM goes to ACK as if acked, and flush_dcache_o drops.
- Macro not defined:
  - No counter is built; timeout_o is tied to 0 and to_limit_i is unused.
  - FLUSH waits indefinitely for the cache ack.

## Test plan
- Single request, cache acks 5 cycles after flush_dcache_o rises:
  - req_i=0001 at edge 0 → flush_dcache_o high cycles 1–5, low from 6.
  - ack_o=0001 for cycle 6 only; busy_o low from 7.
- Coalescing and late arrival, NUM_REQ=4:
  - req 0101 at edge 0, req 1000 at cycle 3, cache ack at cycle 4 → served_mask_o=0101 and ack_o=0101 at cycle 5.
  - Second flush starts with flush_dcache_o high at cycle 7; ack_o=1000 after its own cache ack.
- Minimum latency: cache ack in the first FLUSH cycle → ack_o at cycle 2, IDLE at cycle 3.
- Spurious cache ack in IDLE → no state change, all outputs 0.
- Reset asserted during FLUSH, with the cache ack one cycle after reset release → no ack_o, flush_dcache_o=0, busy_o=0.
- Watchdog compiled in, to_limit_i=8, no cache ack → flush_dcache_o high for 8 cycles; timeout_o and ack_o pulse together in the next cycle.
  - With to_limit_i=0 the flush waits indefinitely and timeout_o stays 0.
